// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch front end: FSM state
// encodings, instruction size in bytes and the word-alignment mask.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_t;

    // Every instruction occupies one 32-bit word.
    localparam int INST_BYTES = 4;

    // Clears the byte-offset bits so any address becomes word aligned.
    // Widths up to 64 bits are supported; narrower users truncate it.
    localparam logic [63:0] ALIGN_MASK = ~64'(INST_BYTES - 1);

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle of the fetch stage's handshakes: start/busy control, the
// instruction-memory req/ack bus, the downstream valid/ready instruction
// channel and the redirect input. The fetch stage uses the master view;
// the surrounding core and memory use the slave view.
interface fetch_stage_if #(
    parameter int ADDR_W = 64,
    parameter int INST_W = 32
);

    logic              i_start;
    logic              o_busy;

    logic              o_imem_req;
    logic [ADDR_W-1:0] o_imem_addr;
    logic              i_imem_ack;
    logic [INST_W-1:0] i_imem_data;

    logic              o_inst_valid;
    logic              i_inst_ready;
    logic [INST_W-1:0] o_inst;
    logic [ADDR_W-1:0] o_pc;

    logic              i_redirect;
    logic [ADDR_W-1:0] i_redirect_pc;

    modport master (
        input  i_start,
        output o_busy,
        output o_imem_req,
        output o_imem_addr,
        input  i_imem_ack,
        input  i_imem_data,
        output o_inst_valid,
        input  i_inst_ready,
        output o_inst,
        output o_pc,
        input  i_redirect,
        input  i_redirect_pc
    );

    modport slave (
        output i_start,
        input  o_busy,
        input  o_imem_req,
        input  o_imem_addr,
        output i_imem_ack,
        output i_imem_data,
        input  o_inst_valid,
        output i_inst_ready,
        input  o_inst,
        input  o_pc,
        output i_redirect,
        output i_redirect_pc
    );

endinterface

// File: rtl/fetch_stage_pc_next.sv
// Next-PC selection for the fetch stage. A live redirect has top priority
// (last redirect wins), then a redirect parked while a request was in
// flight, otherwise the sequential word after the current PC. The aligned
// redirect target is also exported so the stage can park it.
module fetch_pc_next
    import fetch_stage_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              pend,
    input  logic [ADDR_W-1:0] pend_pc,
    output logic [ADDR_W-1:0] next_pc,
    output logic [ADDR_W-1:0] target
);

    localparam logic [ADDR_W-1:0] MASK = ADDR_W'(ALIGN_MASK);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INST_BYTES);

    // Pick the next fetch address; the sequential step wraps naturally.
    always_comb begin
        target = redirect_pc & MASK;
        if (redirect) begin
            next_pc = target;
        end else if (pend) begin
            next_pc = pend_pc;
        end else begin
            next_pc = pc + STEP;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch front end. Owns the architectural PC, issues one word
// request at a time to instruction memory and hands each fetched word and
// its PC downstream. Redirects never disturb an outstanding request: they
// are parked until the request completes and its data is thrown away.
// Every output comes straight from a register or the state register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int              ADDR_W   = 64,
    parameter int              INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    fetch_stage_if.master fe
);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic              pend;
    logic [ADDR_W-1:0] pend_pc;
    logic [ADDR_W-1:0] next_pc;
    logic [ADDR_W-1:0] target;

    logic              imem_req;
    logic              inst_valid;
    logic [INST_W-1:0] inst_q;
    logic [ADDR_W-1:0] pc_q;

    fetch_pc_next #(
        .ADDR_W (ADDR_W)
    ) u_pc_next (
        .pc          (pc),
        .redirect    (fe.i_redirect),
        .redirect_pc (fe.i_redirect_pc),
        .pend        (pend),
        .pend_pc     (pend_pc),
        .next_pc     (next_pc),
        .target      (target)
    );

    // Fetch FSM with its PC, parked-redirect and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= ST_IDLE;
            pc         <= RESET_PC;
            pend       <= 1'b0;
            pend_pc    <= '0;
            imem_req   <= 1'b0;
            inst_valid <= 1'b0;
            inst_q     <= '0;
            pc_q       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fe.i_redirect) begin
                        pc <= next_pc;
                    end
                    if (fe.i_start) begin
                        state    <= ST_FETCH;
                        imem_req <= 1'b1;
                    end
                end

                ST_FETCH: begin
                    if (fe.i_imem_ack) begin
                        if (fe.i_redirect || pend) begin
                            pc   <= next_pc;
                            pend <= 1'b0;
                        end else begin
                            inst_q     <= fe.i_imem_data;
                            pc_q       <= pc;
                            pc         <= next_pc;
                            inst_valid <= 1'b1;
                            imem_req   <= 1'b0;
                            state      <= ST_HOLD;
                        end
                    end else if (fe.i_redirect) begin
                        pend    <= 1'b1;
                        pend_pc <= target;
                    end
                end

                ST_HOLD: begin
                    if (fe.i_redirect) begin
                        pc         <= next_pc;
                        inst_valid <= 1'b0;
                        imem_req   <= 1'b1;
                        state      <= ST_FETCH;
                    end else if (fe.i_inst_ready) begin
                        inst_valid <= 1'b0;
                        imem_req   <= 1'b1;
                        state      <= ST_FETCH;
                    end
                end

                default: begin
                    state      <= ST_IDLE;
                    imem_req   <= 1'b0;
                    inst_valid <= 1'b0;
                    pend       <= 1'b0;
                end
            endcase
        end
    end

    // The request address is the PC register itself, so it cannot move
    // while a request is outstanding.
    assign fe.o_imem_req   = imem_req;
    assign fe.o_imem_addr  = pc;
    assign fe.o_inst_valid = inst_valid;
    assign fe.o_inst       = inst_q;
    assign fe.o_pc         = pc_q;
    assign fe.o_busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage. A memory responder with fixed or
// random wait states and a downstream ready driver surround the DUT. The
// reference model only knows that delivered instructions form a sequential
// word stream restarting at the aligned target of the latest redirect;
// it queues the next expected PC and a monitor pops it on each new
// presentation, alongside protocol checks on both handshakes.
module tb_fetch_stage;

    localparam int          ADDR_W   = 64;
    localparam int          INST_W   = 32;
    localparam logic [63:0] RESET_PC = 64'h0;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int checks = 0;
    int fails  = 0;

    bit mem_random = 1'b0;
    int mem_wait   = 0;
    int ready_mode = 1;

    logic [63:0] exp_q[$];
    logic [63:0] nxt_pc;

    fetch_stage_if #(.ADDR_W(ADDR_W), .INST_W(INST_W)) bus ();

    fetch_stage #(
        .ADDR_W   (ADDR_W),
        .INST_W   (INST_W),
        .RESET_PC (RESET_PC)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .fe      (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return 32'h0000_0013 + a[31:0];
    endfunction

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic check_reset(input string p);
        check_output({p, "_req"},   64'(bus.o_imem_req),   64'h0);
        check_output({p, "_addr"},  bus.o_imem_addr,       RESET_PC);
        check_output({p, "_valid"}, 64'(bus.o_inst_valid), 64'h0);
        check_output({p, "_inst"},  64'(bus.o_inst),       64'h0);
        check_output({p, "_pc"},    bus.o_pc,              64'h0);
        check_output({p, "_busy"},  64'(bus.o_busy),       64'h0);
    endtask

    task automatic reset_dut();
        bus.i_start    = 1'b0;
        bus.i_redirect = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
    endtask

    // One-cycle redirect pulse, driven from a falling edge.
    task automatic apply_stimulus(input logic [63:0] tgt);
        bus.i_redirect    = 1'b1;
        bus.i_redirect_pc = tgt;
        @(negedge clk);
        bus.i_redirect    = 1'b0;
    endtask

    task automatic wait_new_valid(input string name);
        int n = 0;
        while (bus.o_inst_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        while (!bus.o_inst_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_output(name, 64'(bus.o_inst_valid), 64'h1);
    endtask

    // Instruction memory: acks after a chosen number of wait cycles.
    initial begin
        int waited = 0;
        int target = 0;
        bus.i_imem_ack  = 1'b0;
        bus.i_imem_data = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                bus.i_imem_ack = 1'b0;
                waited = 0;
                target = mem_random ? int'($urandom_range(0, 3)) : mem_wait;
            end else begin
                if (bus.i_imem_ack) begin
                    waited = 0;
                    target = mem_random ? int'($urandom_range(0, 3)) : mem_wait;
                end
                bus.i_imem_ack  = 1'b0;
                bus.i_imem_data = $urandom;
                if (bus.o_imem_req) begin
                    if (waited >= target) begin
                        bus.i_imem_ack  = 1'b1;
                        bus.i_imem_data = mem_word(bus.o_imem_addr);
                    end else begin
                        waited++;
                    end
                end
            end
        end
    end

    // Downstream ready: forced low, forced high or random.
    initial begin
        bus.i_inst_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.i_inst_ready = 1'b0;
                1:       bus.i_inst_ready = 1'b1;
                default: bus.i_inst_ready = ($urandom_range(0, 1) == 1);
            endcase
        end
    end

    // Reference model: next expected PC of the delivered stream.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                exp_q.delete();
                nxt_pc = RESET_PC;
                exp_q.push_back(nxt_pc);
            end else if (bus.i_redirect) begin
                exp_q.delete();
                nxt_pc = bus.i_redirect_pc & ~64'h3;
                exp_q.push_back(nxt_pc);
            end else if (exp_q.size() == 0) begin
                nxt_pc = nxt_pc + 64'd4;
                exp_q.push_back(nxt_pc);
            end
        end
    end

    // Monitor: scoreboard pops plus handshake protocol checks.
    initial begin
        logic        pv, preq, pack;
        logic [63:0] ppc, paddr, e;
        logic [31:0] pinst;
        pv = 1'b0; preq = 1'b0; pack = 1'b0;
        ppc = '0; paddr = '0; pinst = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv = 1'b0; preq = 1'b0; pack = 1'b0;
            end else begin
                if (bus.o_inst_valid && !pv) begin
                    check_output("sb_queue", 64'(exp_q.size()), 64'h1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check_output("sb_pc",   bus.o_pc,          e);
                        check_output("sb_inst", 64'(bus.o_inst),   64'(mem_word(e)));
                    end
                end
                if (bus.o_inst_valid && pv) begin
                    check_output("hold_pc",   bus.o_pc,        ppc);
                    check_output("hold_inst", 64'(bus.o_inst), 64'(pinst));
                end
                if (bus.o_inst_valid) begin
                    check_output("hold_no_req", 64'(bus.o_imem_req), 64'h0);
                end
                if (preq && !pack) begin
                    check_output("req_held",  64'(bus.o_imem_req), 64'h1);
                    check_output("addr_held", bus.o_imem_addr,     paddr);
                end
                pv    = bus.o_inst_valid;
                ppc   = bus.o_pc;
                pinst = bus.o_inst;
                preq  = bus.o_imem_req;
                pack  = bus.i_imem_ack;
                paddr = bus.o_imem_addr;
            end
        end
    end

    initial begin
        longint t0;
        int     n;
        int     reqs;
        logic [63:0] tgt;

        bus.i_start       = 1'b0;
        bus.i_redirect    = 1'b0;
        bus.i_redirect_pc = '0;

        // Reset values, then zero-wait streaming with ready high.
        mem_wait = 0; mem_random = 1'b0; ready_mode = 1;
        #2 rst_n = 1'b0;
        #1 check_reset("rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start();
        check_output("busy_after_start", 64'(bus.o_busy), 64'h1);
        wait_new_valid("t1_valid0");
        check_output("t1_pc0",   bus.o_pc,        64'h0);
        check_output("t1_inst0", 64'(bus.o_inst), 64'h13);
        t0 = $time;
        for (int k = 1; k < 4; k++) begin
            wait_new_valid("t1_valid");
            check_output("t1_gap", 64'(($time - t0) / 10), 64'd2);
            check_output("t1_pc",  bus.o_pc, 64'(4 * k));
            t0 = $time;
        end

        // Three wait states on the first request.
        mem_wait = 3;
        reset_dut();
        pulse_start();
        n = 0;
        while (!bus.o_imem_req && n < 20) begin @(negedge clk); n++; end
        check_output("t2_req",  64'(bus.o_imem_req), 64'h1);
        check_output("t2_addr", bus.o_imem_addr,     64'h0);
        n = 0;
        while (bus.o_imem_req && n < 20) begin @(negedge clk); n++; end
        check_output("t2_req_cycles", 64'(n),               64'd4);
        check_output("t2_valid_next", 64'(bus.o_inst_valid), 64'h1);

        // Downstream stalls for five cycles in HOLD.
        ready_mode = 0;
        mem_wait   = 0;
        wait_new_valid("t3_valid");
        reqs = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.o_imem_req) reqs++;
        end
        check_output("t3_valid_held", 64'(bus.o_inst_valid), 64'h1);
        check_output("t3_pc_held",    bus.o_pc,              64'h4);
        check_output("t3_inst_held",  64'(bus.o_inst),       64'(mem_word(64'h4)));
        check_output("t3_no_req",     64'(reqs),             64'h0);
        ready_mode = 1;
        n = 0;
        while (!bus.o_imem_req && n < 20) begin @(negedge clk); n++; end
        check_output("t3_next_req", bus.o_imem_addr, 64'h8);

        // Redirect while the request for 0x8 is still waiting.
        mem_wait = 3;
        reset_dut();
        pulse_start();
        n = 0;
        while (!(bus.o_imem_req && bus.o_imem_addr == 64'h8) && n < 100) begin
            @(negedge clk); n++;
        end
        check_output("t4_reach8", bus.o_imem_addr, 64'h8);
        apply_stimulus(64'h1003);
        n = 0;
        while (!(bus.o_imem_req && bus.o_imem_addr != 64'h8) && n < 50) begin
            @(negedge clk); n++;
        end
        check_output("t4_next_req", bus.o_imem_addr, 64'h1000);
        wait_new_valid("t4_valid");
        check_output("t4_pc", bus.o_pc, 64'h1000);

        // Redirect during HOLD with ready high drops the held word.
        apply_stimulus(64'h200);
        check_output("t5_valid_drop", 64'(bus.o_inst_valid), 64'h0);
        check_output("t5_req",        64'(bus.o_imem_req),   64'h1);
        check_output("t5_addr",       bus.o_imem_addr,       64'h200);

        // Redirect coincident with an ack drops that data.
        mem_wait = 0;
        n = 0;
        while (!(bus.o_imem_req && bus.i_imem_ack) && n < 20) begin @(negedge clk); n++; end
        check_output("t5_ack_seen", 64'(bus.i_imem_ack), 64'h1);
        apply_stimulus(64'h300);
        check_output("t5b_valid", 64'(bus.o_inst_valid), 64'h0);
        check_output("t5b_req",   64'(bus.o_imem_req),   64'h1);
        check_output("t5b_addr",  bus.o_imem_addr,       64'h300);
        wait_new_valid("t5b_present");
        check_output("t5b_pc", bus.o_pc, 64'h300);

        // Start together with an unaligned redirect at the top of memory.
        mem_wait = 0;
        reset_dut();
        bus.i_start       = 1'b1;
        bus.i_redirect    = 1'b1;
        bus.i_redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE;
        @(negedge clk);
        bus.i_start    = 1'b0;
        bus.i_redirect = 1'b0;
        check_output("t6_first_req", bus.o_imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        wait_new_valid("t6_valid");
        check_output("t6_pc", bus.o_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        @(negedge clk);
        check_output("t6_wrap_req",  64'(bus.o_imem_req), 64'h1);
        check_output("t6_wrap_addr", bus.o_imem_addr,     64'h0);

        // Asynchronous reset while a request waits for its ack.
        mem_wait = 3;
        reset_dut();
        pulse_start();
        @(negedge clk);
        check_output("t7_in_fetch", 64'(bus.o_imem_req), 64'h1);
        #2 rst_n = 1'b0;
        #1 check_reset("t7");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Random traffic: wait states, ready, redirects and a mid-run reset.
        mem_random = 1'b1;
        ready_mode = 2;
        reset_dut();
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                reset_dut();
            end
            bus.i_start = !bus.o_busy && ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 3))
                    0:       tgt = {$urandom(), $urandom()};
                    1:       tgt = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
                    default: tgt = 64'($urandom_range(0, 4095));
                endcase
                bus.i_redirect    = 1'b1;
                bus.i_redirect_pc = tgt;
            end else begin
                bus.i_redirect = 1'b0;
            end
            @(negedge clk);
        end
        bus.i_start    = 1'b0;
        bus.i_redirect = 1'b0;
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction fetch front end of the CPU datapath. It owns the architectural PC and issues word requests to instruction memory over a req/ack handshake. It presents each fetched instruction and its PC downstream with a valid/ready handshake, and accepts branch/jump redirects. The PC output feeds the downstream registered PC/branch-target adder.

Parameters:
ADDR_W, 64, width of PC and memory address
INST_W, 32, instruction width
RESET_PC, 0, PC value loaded at reset

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  reset, asynchronous, active-low
i_start  input  1  one-cycle pulse, leaves IDLE and begins fetching
o_imem_req  output  1  memory request valid
o_imem_addr  output  ADDR_W  request address, word aligned
i_imem_ack  input  1  memory accepted request, data valid this cycle
i_imem_data  input  INST_W  instruction word, sampled when i_imem_ack=1
o_inst_valid  output  1  o_inst/o_pc valid
i_inst_ready  input  1  downstream accepts instruction
o_inst  output  INST_W  fetched instruction
o_pc  output  ADDR_W  PC of o_inst
i_redirect  input  1  load new PC
i_redirect_pc  input  ADDR_W  redirect target
o_busy  output  1  state != IDLE

Behaviour:
- Reset values:
  - pc=RESET_PC, state=IDLE, pending-redirect flag cleared.
  - o_imem_req=0, o_imem_addr=RESET_PC, o_inst_valid=0, o_inst=0, o_pc=0, o_busy=0.
- Alignment: the redirect target is stored with bits [1:0] forced to 0. PC increment is pc+4, wrapping modulo 2^ADDR_W.
- States: IDLE, FETCH, HOLD. All outputs are registered or driven from state/registers only. No combinational path from any input to any output.
- IDLE:
  - o_imem_req=0.
  - i_start=1 -> FETCH next cycle.
  - i_redirect in IDLE loads pc and stays in IDLE.
  - If i_start and i_redirect are asserted together, the redirect target is the first fetch address.
- FETCH:
  - o_imem_req=1, o_imem_addr=pc, held stable until i_imem_ack is sampled high.
  - Ack may arrive in the first FETCH cycle (zero wait).
  - On ack with no redirect pending: o_inst<=i_imem_data, o_pc<=pc, pc<=pc+4, o_inst_valid<=1, -> HOLD.
- Latency: ack cycle N gives o_inst_valid=1 in cycle N+1. A handshake in cycle M gives o_imem_req=1 in cycle M+1. Peak throughput is one instruction per 2 cycles.
- HOLD:
  - o_inst_valid=1, and o_inst/o_pc are held stable until i_inst_ready=1.
  - On i_inst_ready: o_inst_valid<=0, -> FETCH.
- Redirect in FETCH:
  - Address must not change while a request is outstanding.
  - Without ack: store the target in a redirect register and set the pending flag. The current request completes normally; its data is discarded (no o_inst_valid). Then FETCH re-issues at the target.
  - With ack in the same cycle: data is discarded, pc<=target, stay in FETCH. o_imem_req stays 1 with the new address next cycle.
  - A second redirect while one is pending overwrites the target (last wins).
  - A redirect in the same cycle as the discarding ack wins over the pending target.
- Redirect in HOLD: o_inst_valid<=0 next cycle, pc<=target, -> FETCH. This holds whether or not i_inst_ready is high; redirect wins and the held instruction is dropped.
- Asynchronous reset mid-operation forces the reset values immediately. Any in-flight memory transaction is abandoned; the memory side must also be reset.

Decomposition:
- Shared package/include holds the state encodings (IDLE/FETCH/HOLD), INST_BYTES=4, and the alignment mask.
- One natural sub-module: fetch_pc_next. It is combinational and selects among pc+4, redirect target and pending target, and applies alignment. Keep the FSM and registers in fetch_stage.

Test Plan:
- Reset, pulse i_start, memory acks every request zero-wait with data=0x00000013+addr, i_inst_ready=1 -> o_pc sequence 0,4,8,12 with matching o_inst, valid every other cycle.
- Memory ack delayed 3 cycles -> o_imem_req=1 and o_imem_addr=0x0 stable for 4 cycles, o_inst_valid rises the cycle after ack.
- Downstream ready low for 5 cycles in HOLD -> o_inst/o_pc unchanged, no new o_imem_req until the handshake.
- Redirect to 0x1003 while FETCH awaits ack for 0x8 -> data for 0x8 never appears valid, next request address 0x1000, next o_pc=0x1000.
- Redirect to 0x200 in HOLD with i_inst_ready=1 -> o_inst_valid=0 next cycle, next request 0x200. Redirect coincident with ack -> ack data dropped.
- PC=2^64-4 fetched -> next request 0x0 (wrap). Assert i_rst_n=0 during the FETCH wait -> all outputs at reset values immediately, state IDLE.
